// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Two-port arbiter in front of a single-ported word memory. Port 0 is the
// fetch unit, port 1 the stack/data unit. Each transaction takes exactly three
// cycles: IDLE (request sampled and latched) -> ACCESS (memory driven, write
// strobe for writes, read data captured at the end) -> RESP (done pulse).
//
// Arbitration: round-robin between the two ports. With the macro
// ARB_FIXED_PRIO_EN defined, port 1 always wins ties and the round-robin
// history register is not built.
//
// Ports
//   clk              single clock, rising edge
//   rst_n            asynchronous active-low reset
//   req0/req1        access request per port
//   we0/we1          1 = write, 0 = read (qualified by reqN)
//   addr0/addr1      word address per port
//   wdata0/wdata1    write data per port
//   gnt0/gnt1        port owns the memory (ACCESS and RESP)
//   done0/done1      one-cycle completion pulse (RESP)
//   rdata0/rdata1    registered read data, held until the port's next read
//   busy             FSM not in IDLE
//   mem_addr/mem_wd  memory address / write data (0 while idle)
//   mem_we           memory write strobe, one ACCESS cycle per write
//   mem_rd           combinational memory read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rd
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              state_reg;
   logic                lat_port_reg;   // winner of the current transaction
   logic                lat_we_reg;     // latched write flag of the winner
   logic                gnt0_reg;
   logic                gnt1_reg;
   logic                done0_reg;
   logic                done1_reg;
   logic                busy_reg;
   logic                mem_we_reg;
   logic [ADDR_W-1:0]   mem_addr_reg;   // doubles as the latched address
   logic [DATA_W-1:0]   mem_wd_reg;     // doubles as the latched write data

   // Winner selection and the request fields of that winner
   logic                win_next;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

`ifndef ARB_FIXED_PRIO_EN
   // Port served by the most recent transaction; reset to 1 so that
   // port 0 wins the first tie.
   logic                last_served_reg;
`endif

   always_comb begin
      win_next = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      // Port 1 wins whenever it asks.
      win_next = req1;
`else
      // A lone requester wins outright; on a tie the port that was not
      // served last time goes first.
      if (req0 && req1) begin
         win_next = ~last_served_reg;
      end else begin
         win_next = req1;
      end
`endif
      sel_we    = win_next ? we1    : we0;
      sel_addr  = win_next ? addr1  : addr0;
      sel_wdata = win_next ? wdata1 : wdata0;
   end

   // -------------------------------------------------------------------------
   // Transaction FSM. All outputs except read data are registered here so
   // they change only on clock edges (or immediately on reset).
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         lat_port_reg    <= 1'b0;
         lat_we_reg      <= 1'b0;
         gnt0_reg        <= 1'b0;
         gnt1_reg        <= 1'b0;
         done0_reg       <= 1'b0;
         done1_reg       <= 1'b0;
         busy_reg        <= 1'b0;
         mem_we_reg      <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wd_reg      <= '0;
`ifndef ARB_FIXED_PRIO_EN
         last_served_reg <= 1'b1;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (req0 || req1) begin
                  state_reg    <= ACCESS;
                  lat_port_reg <= win_next;
                  lat_we_reg   <= sel_we;
                  gnt0_reg     <= ~win_next;
                  gnt1_reg     <= win_next;
                  busy_reg     <= 1'b1;
                  mem_addr_reg <= sel_addr;
                  mem_wd_reg   <= sel_wdata;
                  // Write strobe covers exactly the ACCESS cycle.
                  mem_we_reg   <= sel_we;
`ifndef ARB_FIXED_PRIO_EN
                  last_served_reg <= win_next;
`endif
               end
            end

            ACCESS: begin
               state_reg  <= RESP;
               mem_we_reg <= 1'b0;
               done0_reg  <= ~lat_port_reg;
               done1_reg  <= lat_port_reg;
            end

            RESP: begin
               state_reg    <= IDLE;
               gnt0_reg     <= 1'b0;
               gnt1_reg     <= 1'b0;
               done0_reg    <= 1'b0;
               done1_reg    <= 1'b0;
               busy_reg     <= 1'b0;
               mem_addr_reg <= '0;
               mem_wd_reg   <= '0;
            end

            default: begin
               state_reg    <= IDLE;
               gnt0_reg     <= 1'b0;
               gnt1_reg     <= 1'b0;
               done0_reg    <= 1'b0;
               done1_reg    <= 1'b0;
               busy_reg     <= 1'b0;
               mem_we_reg   <= 1'b0;
               mem_addr_reg <= '0;
               mem_wd_reg   <= '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Per-port read data registers. A port's register loads only at the end of
   // ACCESS of its own read; writes and the other port's reads leave it alone.
   // -------------------------------------------------------------------------
   logic [1:0][DATA_W-1:0] rdata_vec;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         localparam logic PORT_ID = 1'(gi);
         logic [DATA_W-1:0] rd_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_reg <= '0;
            end else if (state_reg == ACCESS && !lat_we_reg &&
                         lat_port_reg == PORT_ID) begin
               rd_reg <= mem_rd;
            end
         end

         assign rdata_vec[gi] = rd_reg;
      end
   endgenerate

   assign gnt0     = gnt0_reg;
   assign gnt1     = gnt1_reg;
   assign done0    = done0_reg;
   assign done1    = done1_reg;
   assign busy     = busy_reg;
   assign mem_we   = mem_we_reg;
   assign mem_addr = mem_addr_reg;
   assign mem_wd   = mem_wd_reg;
   assign rdata0   = rdata_vec[0];
   assign rdata1   = rdata_vec[1];

endmodule
